// File: rtl/usb_pkg.sv
// Shared types and defaults for the full-speed USB receive path.
// Line-state codes, receiver states, error codes, bit-reverse helper.
package usb_pkg;

  localparam int STUFF_LEN_DEF      = 6;
  localparam int SYNC_MIN_ZEROS_DEF = 5;

  // Encodings match {dp, dm} so the line can be cast directly.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_SYNC  = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_EOP   = 3'd3;
  localparam rx_state_t ST_ERROR = 3'd4;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_STUFF    = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_FRAMING  = 2'd3
  } rx_err_t;

  function automatic logic [7:0] bit_rev8(
    input logic [7:0] d
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_shift_register.sv
// Serial-in parallel-out byte assembler, MSB-first shift.
// Ports: clk, rst_n, shift_enable, serial_in -> parallel_out, done.
module sipo_shift_register
  import usb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parallel_out <= '0;
      cnt          <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (shift_enable) begin
        parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
        if (cnt == CW'(WIDTH - 1)) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx_controller.sv
// Full-speed USB receive sequencer: NRZI, SYNC, unstuff, EOP, byte out.
// Ports: CLK, nRST, bit_strobe, dp, dm, rx_ready -> rx_data/valid, status.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int STUFF_LEN      = STUFF_LEN_DEF
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       bit_strobe,
  input  logic       dp,
  input  logic       dm,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       packet_start,
  output logic       packet_end,
  output logic       rx_error,
  output logic [1:0] err_code
);

  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);

  line_state_t ls;
  line_state_t prev_ls;
  rx_state_t   state;
  rx_err_t     err_q;

  logic [ZW-1:0] zero_cnt;
  logic [OW-1:0] ones_cnt;
  logic [2:0]    bit_cnt;
  logic          shift_en;
  logic          shift_bit;
  logic          last_bit;
  logic          cap_q;
  logic          seen_se0;
  logic [7:0]    sipo_q;
  logic          sipo_done_unused;
  logic          is_jk;
  logic          dbit;

  assign ls       = line_state_t'({dp, dm});
  assign is_jk    = (ls == LS_J) || (ls == LS_K);
  assign dbit     = (ls == prev_ls);
  assign err_code = err_q;

  sipo_shift_register #(
    .WIDTH(8)
  ) u_sipo (
    .clk         (CLK),
    .rst_n       (nRST),
    .shift_enable(shift_en),
    .serial_in   (shift_bit),
    .parallel_out(sipo_q),
    .done        (sipo_done_unused)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      prev_ls      <= LS_J;
      err_q        <= ERR_NONE;
      zero_cnt     <= '0;
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      shift_en     <= 1'b0;
      shift_bit    <= 1'b0;
      last_bit     <= 1'b0;
      cap_q        <= 1'b0;
      seen_se0     <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_active    <= 1'b0;
      packet_start <= 1'b0;
      packet_end   <= 1'b0;
      rx_error     <= 1'b0;
    end else begin
      packet_start <= 1'b0;
      packet_end   <= 1'b0;
      rx_error     <= 1'b0;
      shift_en     <= 1'b0;
      // Capture trails the 8th shift by one cycle so the SIPO is full.
      cap_q        <= shift_en && last_bit;

      if (packet_end) begin
        rx_active <= 1'b0;
      end

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (cap_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= bit_rev8(sipo_q);
          rx_valid <= 1'b1;
        end else begin
          rx_error <= 1'b1;
          err_q    <= ERR_OVERFLOW;
          state    <= ST_ERROR;
          seen_se0 <= 1'b0;
        end
      end

      if (bit_strobe) begin
        if (is_jk) begin
          prev_ls <= ls;
        end

        unique case (state)
          ST_IDLE: begin
            if (ls == LS_K) begin
              state    <= ST_SYNC;
              zero_cnt <= ZW'(1);
            end else begin
              prev_ls <= LS_J;
            end
          end

          ST_SYNC: begin
            if (!is_jk) begin
              state   <= ST_IDLE;
              prev_ls <= LS_J;
            end else if (!dbit) begin
              if (zero_cnt != ZW'(SYNC_MIN_ZEROS)) begin
                zero_cnt <= zero_cnt + 1'b1;
              end
            end else if (zero_cnt >= ZW'(SYNC_MIN_ZEROS)) begin
              state        <= ST_DATA;
              packet_start <= 1'b1;
              rx_active    <= 1'b1;
              err_q        <= ERR_NONE;
              bit_cnt      <= '0;
              ones_cnt     <= '0;
            end else begin
              state   <= ST_IDLE;
              prev_ls <= LS_J;
            end
          end

          ST_DATA: begin
            unique case (1'b1)
              (ls == LS_SE0): begin
                state <= ST_EOP;
              end
              (ls == LS_SE1): begin
                rx_error <= 1'b1;
                err_q    <= ERR_FRAMING;
                state    <= ST_ERROR;
                seen_se0 <= 1'b0;
              end
              is_jk: begin
                if (ones_cnt == OW'(STUFF_LEN)) begin
                  // Stuffed bit: a 0 is discarded, a 1 is illegal.
                  if (dbit) begin
                    rx_error <= 1'b1;
                    err_q    <= ERR_STUFF;
                    state    <= ST_ERROR;
                    seen_se0 <= 1'b0;
                  end else begin
                    ones_cnt <= '0;
                  end
                end else begin
                  ones_cnt  <= dbit ? ones_cnt + 1'b1 : '0;
                  shift_en  <= 1'b1;
                  shift_bit <= dbit;
                  last_bit  <= (bit_cnt == 3'd7);
                  bit_cnt   <= bit_cnt + 3'd1;
                end
              end
            endcase
          end

          ST_EOP: begin
            if (ls == LS_J) begin
              packet_end <= 1'b1;
              state      <= ST_IDLE;
              prev_ls    <= LS_J;
              if (bit_cnt != 3'd0) begin
                rx_error <= 1'b1;
                err_q    <= ERR_FRAMING;
              end
            end else if (ls != LS_SE0) begin
              rx_error <= 1'b1;
              err_q    <= ERR_FRAMING;
              state    <= ST_ERROR;
              seen_se0 <= 1'b0;
            end
          end

          ST_ERROR: begin
            if (ls == LS_SE0) begin
              seen_se0 <= 1'b1;
            end else if (ls == LS_J && seen_se0) begin
              packet_end <= 1'b1;
              state      <= ST_IDLE;
              prev_ls    <= LS_J;
            end
          end

          default: begin
            state   <= ST_IDLE;
            prev_ls <= LS_J;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_controller.sv
// Self-checking bench for usb_rx_controller.
// Packets are built from byte intent; expectations come from that intent.
module tb_usb_rx_controller;
  import usb_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       packet_start;
  logic       packet_end;
  logic       rx_error;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  int n_start = 0;
  int n_end = 0;
  int n_err = 0;
  int n_end_err = 0;
  logic [7:0] got[$];

  logic [1:0] sym[$];
  logic [1:0] lvl;
  int         ones;

  always #5 CLK = ~CLK;

  usb_rx_controller dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bit_strobe  (bit_strobe),
    .dp          (dp),
    .dm          (dm),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_active   (rx_active),
    .packet_start(packet_start),
    .packet_end  (packet_end),
    .rx_error    (rx_error),
    .err_code    (err_code)
  );

  always @(negedge CLK) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (packet_start) n_start++;
    if (packet_end) n_end++;
    if (rx_error) n_err++;
    if (packet_end && rx_error) n_end_err++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic strobe_only(input logic [1:0] s);
    dp = s[1];
    dm = s[0];
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
  endtask

  task automatic send(input logic [1:0] s);
    strobe_only(s);
    repeat (3 + $urandom_range(0, 2)) tick();
  endtask

  task automatic enc_bit(input logic b);
    if (!b) lvl = ~lvl;
    sym.push_back(lvl);
  endtask

  task automatic data_bit(input logic b);
    enc_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      enc_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic begin_pkt();
    sym.delete();
    lvl = 2'b10;
    repeat (7) enc_bit(1'b0);
    enc_bit(1'b1);
    ones = 0;
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) data_bit(v[i]);
  endtask

  task automatic end_pkt();
    sym.push_back(2'b00);
    sym.push_back(2'b00);
    sym.push_back(2'b10);
  endtask

  task automatic play();
    while (sym.size() > 0) send(sym.pop_front());
    repeat (4) tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rx_data, rx_valid, rx_active, packet_start, packet_end,
         rx_error, err_code} !== 15'd0) begin
      errors++;
      $display("FAIL reset_hold got %h want 0",
               {rx_data, rx_valid, rx_active, err_code});
    end
    nRST = 1'b1;
    repeat (2) tick();
    checks++;
    if ({rx_data, rx_valid, rx_active, packet_start, packet_end,
         rx_error, err_code} !== 15'd0) begin
      errors++;
      $display("FAIL reset_rel got %h want 0",
               {rx_data, rx_valid, rx_active, err_code});
    end
  endtask

  task automatic test_basic();
    int b0 = got.size();
    int e0 = n_end;
    int r0 = n_err;
    begin_pkt();
    add_byte(8'hA5);
    end_pkt();
    for (int i = 0; i < 7; i++) send(sym.pop_front());
    strobe_only(sym.pop_front());
    @(negedge CLK);
    checks++;
    if (packet_start !== 1'b1 || rx_active !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got %b%b want 11",
               packet_start, rx_active);
    end
    repeat (3) tick();
    for (int i = 0; i < 7; i++) send(sym.pop_front());
    strobe_only(sym.pop_front());
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got %b want 0", rx_valid);
    end
    @(negedge CLK);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_byte got %b/%h want 1/a5", rx_valid, rx_data);
    end
    repeat (3) tick();
    play();
    checks++;
    if (n_end - e0 !== 1 || rx_active !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got %0d/%b want 1/0", n_end - e0, rx_active);
    end
    checks++;
    if (err_code !== 2'd0 || n_err - r0 !== 0) begin
      errors++;
      $display("FAIL basic_err got %0d/%0d want 0/0", err_code, n_err - r0);
    end
    checks++;
    if (got.size() - b0 !== 1) begin
      errors++;
      $display("FAIL basic_count got %0d want 1", got.size() - b0);
    end
  endtask

  task automatic test_stuff();
    int b0 = got.size();
    int r0 = n_err;
    begin_pkt();
    add_byte(8'hFF);
    add_byte(8'h01);
    end_pkt();
    play();
    checks++;
    if (got.size() - b0 !== 2) begin
      errors++;
      $display("FAIL stuff_count got %0d want 2", got.size() - b0);
    end else begin
      checks++;
      if (got[b0] !== 8'hFF || got[b0+1] !== 8'h01) begin
        errors++;
        $display("FAIL stuff_data got %h %h want ff 01", got[b0], got[b0+1]);
      end
    end
    checks++;
    if (err_code !== 2'd0 || n_err - r0 !== 0) begin
      errors++;
      $display("FAIL stuff_err got %0d want 0", err_code);
    end
  endtask

  task automatic test_stuff_error();
    int b0 = got.size();
    int e0 = n_end;
    int r0 = n_err;
    begin_pkt();
    repeat (7) enc_bit(1'b1);
    play();
    checks++;
    if (err_code !== 2'd1 || n_err - r0 !== 1) begin
      errors++;
      $display("FAIL stuff_e_code got %0d/%0d want 1/1", err_code, n_err - r0);
    end
    checks++;
    if (got.size() - b0 !== 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stuff_e_nobyte got %0d want 0", got.size() - b0);
    end
    sym.push_back(2'b10);
    sym.push_back(2'b10);
    play();
    checks++;
    if (n_end - e0 !== 0 || rx_active !== 1'b1) begin
      errors++;
      $display("FAIL stuff_e_hold got %0d/%b want 0/1", n_end - e0, rx_active);
    end
    sym.push_back(2'b00);
    sym.push_back(2'b10);
    play();
    checks++;
    if (n_end - e0 !== 1 || rx_active !== 1'b0) begin
      errors++;
      $display("FAIL stuff_e_exit got %0d/%b want 1/0", n_end - e0, rx_active);
    end
  endtask

  task automatic test_overflow();
    int b0 = got.size();
    int e0 = n_end;
    int r0 = n_err;
    rx_ready = 1'b0;
    begin_pkt();
    add_byte(8'h12);
    add_byte(8'h34);
    end_pkt();
    play();
    checks++;
    if (err_code !== 2'd2 || n_err - r0 !== 1) begin
      errors++;
      $display("FAIL ovf_code got %0d/%0d want 2/1", err_code, n_err - r0);
    end
    checks++;
    if (rx_data !== 8'h12 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got %h/%b want 12/1", rx_data, rx_valid);
    end
    checks++;
    if (n_end - e0 !== 1) begin
      errors++;
      $display("FAIL ovf_end got %0d want 1", n_end - e0);
    end
    rx_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (got.size() - b0 !== 1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got %0d/%b want 1/0", got.size() - b0, rx_valid);
    end else begin
      checks++;
      if (got[b0] !== 8'h12) begin
        errors++;
        $display("FAIL ovf_drain_data got %h want 12", got[b0]);
      end
    end
  endtask

  task automatic test_framing();
    int b0 = got.size();
    int e0 = n_end;
    int r0 = n_err;
    int x0 = n_end_err;
    logic [7:0] v = 8'($urandom);
    logic [3:0] nib = 4'($urandom);
    begin_pkt();
    add_byte(v);
    for (int i = 0; i < 4; i++) data_bit(nib[i]);
    end_pkt();
    play();
    checks++;
    if (got.size() - b0 !== 1) begin
      errors++;
      $display("FAIL frame_count got %0d want 1", got.size() - b0);
    end else begin
      checks++;
      if (got[b0] !== v) begin
        errors++;
        $display("FAIL frame_data got %h want %h", got[b0], v);
      end
    end
    checks++;
    if (err_code !== 2'd3 || n_err - r0 !== 1) begin
      errors++;
      $display("FAIL frame_code got %0d/%0d want 3/1", err_code, n_err - r0);
    end
    checks++;
    if (n_end - e0 !== 1 || n_end_err - x0 !== 1) begin
      errors++;
      $display("FAIL frame_end got %0d/%0d want 1/1", n_end - e0, n_end_err - x0);
    end
  endtask

  task automatic test_se1();
    int b0 = got.size();
    int e0 = n_end;
    int r0 = n_err;
    begin_pkt();
    for (int i = 0; i < 3; i++) data_bit(1'($urandom));
    sym.push_back(2'b11);
    sym.push_back(2'b00);
    sym.push_back(2'b10);
    play();
    checks++;
    if (err_code !== 2'd3 || n_err - r0 !== 1 || n_end - e0 !== 1) begin
      errors++;
      $display("FAIL se1 got %0d/%0d/%0d want 3/1/1",
               err_code, n_err - r0, n_end - e0);
    end
    checks++;
    if (got.size() - b0 !== 0) begin
      errors++;
      $display("FAIL se1_nobyte got %0d want 0", got.size() - b0);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    int r0;
    begin_pkt();
    for (int i = 0; i < 3; i++) data_bit(1'($urandom));
    play();
    nRST = 1'b0;
    #1;
    checks++;
    if (rx_active !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL rstmid got %b/%0d want 0/0", rx_active, err_code);
    end
    repeat (2) tick();
    nRST = 1'b1;
    repeat (2) tick();
    b0 = got.size();
    r0 = n_err;
    begin_pkt();
    add_byte(8'h3C);
    end_pkt();
    play();
    checks++;
    if (got.size() - b0 !== 1) begin
      errors++;
      $display("FAIL rstmid_count got %0d want 1", got.size() - b0);
    end else begin
      checks++;
      if (got[b0] !== 8'h3C) begin
        errors++;
        $display("FAIL rstmid_data got %h want 3c", got[b0]);
      end
    end
    checks++;
    if (err_code !== 2'd0 || n_err - r0 !== 0) begin
      errors++;
      $display("FAIL rstmid_err got %0d want 0", err_code);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [1:0] noise[3];
    noise[0] = 2'b10;
    noise[1] = 2'b00;
    noise[2] = 2'b11;
    for (int p = 0; p < 20; p++) begin
      int b0 = got.size();
      int s0 = n_start;
      int e0 = n_end;
      int r0 = n_err;
      int nb = $urandom_range(1, 4);
      exp.delete();
      repeat ($urandom_range(0, 2)) send(noise[$urandom_range(0, 2)]);
      send(2'b10);
      begin_pkt();
      for (int i = 0; i < nb; i++) begin
        logic [7:0] v;
        v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        exp.push_back(v);
        add_byte(v);
      end
      end_pkt();
      play();
      checks++;
      if (got.size() - b0 !== nb) begin
        errors++;
        $display("FAIL rand%0d_count got %0d want %0d", p, got.size() - b0, nb);
      end else begin
        for (int i = 0; i < nb; i++) begin
          checks++;
          if (got[b0+i] !== exp[i]) begin
            errors++;
            $display("FAIL rand%0d_byte%0d got %h want %h",
                     p, i, got[b0+i], exp[i]);
          end
        end
      end
      checks++;
      if (n_start - s0 !== 1 || n_end - e0 !== 1 || n_err - r0 !== 0
          || err_code !== 2'd0) begin
        errors++;
        $display("FAIL rand%0d_flags got %0d/%0d/%0d/%0d want 1/1/0/0",
                 p, n_start - s0, n_end - e0, n_err - r0, err_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_stuff_error();
    test_overflow();
    test_framing();
    test_se1();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
